// File: rtl/capture_trig_ctrl.sv
// Capture sequencer: pre-trigger fill, arm, post-trigger count into a circular sample RAM.
// Optional auto-trigger after AUTO_TIMEOUT armed clocks is built when CAPTURE_AUTO_TRIG_EN is defined.
module capture_trig_ctrl #(
    parameter int ENTRIES      = 512,
    parameter int ADDR_W       = 9,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              trig_in,
    input  logic              smpl_en,
    input  logic              done_ack,
    output logic              set_armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              triggered,
    output logic              capture_done,
    output logic              busy
`ifdef CAPTURE_AUTO_TRIG_EN
    ,
    output logic              auto_trig
`endif
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] post_q;      // effective post-trigger count, latched on start
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_inc;
    logic [CW-1:0]     fill_cnt;
    logic [CW-1:0]     post_ext;
    logic [ADDR_W-1:0] post_clamped;
    logic              auto_fire;
    logic              trig_fire;

    assign cnt_inc      = cnt_q + 1'b1;
    assign post_ext     = {1'b0, post_q};
    assign fill_cnt     = CW'(ENTRIES) - post_ext;
    assign post_clamped = (trig_pos > ADDR_W'(ENTRIES - 1)) ? ADDR_W'(ENTRIES - 1) : trig_pos;
    assign trig_fire    = trig_in || auto_fire;

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int AW = $clog2(AUTO_TIMEOUT + 1);
    logic [AW-1:0] auto_cnt_q;

    // Cleared whenever not ARMED, so it starts at zero on entry.
    assign auto_fire = (state_q == ARMED) && !trig_in && (auto_cnt_q == AW'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt_q <= '0;
            auto_trig  <= 1'b0;
        end else begin
            auto_cnt_q <= (state_q == ARMED) ? auto_cnt_q + 1'b1 : '0;
            if (state_q == IDLE && start)
                auto_trig <= 1'b0;
            else if (auto_fire)
                auto_trig <= 1'b1;
        end
    end
`else
    logic unused_auto_timeout;
    assign unused_auto_timeout = (AUTO_TIMEOUT != 0);
    assign auto_fire           = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        we           = 1'b0;
        capture_done = 1'b0;
        busy         = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = FILL;
            end
            FILL: begin
                we = smpl_en;
                if (smpl_en && cnt_inc == fill_cnt)
                    state_d = ARMED;
            end
            ARMED: begin
                we = smpl_en;
                if (trig_fire) begin
                    // A sample taken on the trigger clock is the first post sample.
                    if (post_q == '0 || CW'(smpl_en) == post_ext)
                        state_d = DONE;
                    else
                        state_d = POST;
                end
            end
            POST: begin
                we = smpl_en;
                if (smpl_en && cnt_inc == post_ext)
                    state_d = DONE;
            end
            DONE: begin
                capture_done = 1'b1;
                if (done_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= IDLE;
            set_armed <= 1'b0;
            waddr     <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            post_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            set_armed <= (state_q == ARMED) && (state_d == ARMED);
            if (we)
                waddr <= (waddr == ADDR_W'(ENTRIES - 1)) ? '0 : waddr + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        waddr     <= '0;
                        cnt_q     <= '0;
                        triggered <= 1'b0;
                        post_q    <= post_clamped;
                    end
                end
                FILL: begin
                    if (smpl_en)
                        cnt_q <= (state_d == ARMED) ? '0 : cnt_inc;
                end
                ARMED: begin
                    if (trig_fire) begin
                        triggered <= trig_in;
                        trig_addr <= waddr;
                        cnt_q     <= CW'(smpl_en);
                    end
                end
                POST: begin
                    if (smpl_en)
                        cnt_q <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_trig_ctrl.sv
// Self-checking bench for capture_trig_ctrl (ENTRIES=16, ADDR_W=5); write addresses go through a scoreboard queue.
// Define CAPTURE_AUTO_TRIG_EN to also exercise the auto-trigger.
module tb_capture_trig_ctrl;

    localparam int ENTRIES      = 16;
    localparam int ADDR_W       = 5;
    localparam int AUTO_TIMEOUT = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] trig_pos;
    logic              trig_in;
    logic              smpl_en;
    logic              done_ack;
    logic              set_armed;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trig_addr;
    logic              triggered;
    logic              capture_done;
    logic              busy;
`ifdef CAPTURE_AUTO_TRIG_EN
    logic              auto_trig;
`endif

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;

    capture_trig_ctrl #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .trig_pos(trig_pos), .trig_in(trig_in),
        .smpl_en(smpl_en), .done_ack(done_ack), .set_armed(set_armed), .we(we),
        .waddr(waddr), .trig_addr(trig_addr), .triggered(triggered),
        .capture_done(capture_done), .busy(busy)
`ifdef CAPTURE_AUTO_TRIG_EN
        , .auto_trig(auto_trig)
`endif
    );

    always #5 clk = ~clk;

    // Every RAM write must match the next expected address.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] w;
        if (we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: waddr=%0d written, required no write", waddr);
            end else begin
                w = exp_q.pop_front();
                if (waddr !== w) begin
                    errors++;
                    $display("FAIL write_addr: waddr=%0d, required %0d", waddr, w);
                end
            end
        end
    end

    task automatic cycle(input logic s, input logic t, input bit push);
        smpl_en = s;
        trig_in = t;
        if (push) begin
            exp_q.push_back(exp_addr);
            exp_addr = (exp_addr == ADDR_W'(ENTRIES - 1)) ? '0 : exp_addr + 1'b1;
        end
        @(posedge clk);
        #1;
        smpl_en = 1'b0;
        trig_in = 1'b0;
    endtask

    task automatic sample(input int gap, input logic t);
        for (int i = 0; i < gap; i++) cycle(1'b0, t, 1'b0);
        cycle(1'b1, t, 1'b1);
    endtask

    task automatic pulse_start(input int p_in);
        trig_pos = ADDR_W'(p_in);
        exp_addr = '0;
        start    = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        start    = 1'b0;
    endtask

    task automatic finish_capture(input string tag);
        checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL %s done: capture_done=%b, required 1", tag, capture_done); end
        checks++; if (set_armed !== 1'b0) begin errors++; $display("FAIL %s done_armed: set_armed=%b, required 0", tag, set_armed); end
        smpl_en = 1'b1;
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL %s we_after_done: we=%b, required 0", tag, we); end
        cycle(1'b1, 1'b0, 1'b0);
        done_ack = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        done_ack = 1'b0;
        checks++; if (capture_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s ack: capture_done=%b busy=%b, required 0 0", tag, capture_done, busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s missing_writes: %0d pending, required 0", tag, exp_q.size()); end
    endtask

    // Full capture: n_armed writes in ARMED before the trigger, gap idle clocks between samples.
    task automatic capture(input string tag, input int p_in, input int n_armed, input int gap, input logic fill_trig);
        int p, f;
        logic [ADDR_W-1:0] ta;
        p = (p_in > ENTRIES - 1) ? ENTRIES - 1 : p_in;
        f = ENTRIES - p;
        pulse_start(p_in);
        checks++; if (busy !== 1'b1 || waddr !== '0 || triggered !== 1'b0) begin errors++; $display("FAIL %s start: busy=%b waddr=%0d triggered=%b, required 1 0 0", tag, busy, waddr, triggered); end
        for (int i = 0; i < f; i++) sample(gap, fill_trig);
        checks++; if (set_armed !== 1'b0 || triggered !== 1'b0) begin errors++; $display("FAIL %s armed_entry: set_armed=%b triggered=%b, required 0 0", tag, set_armed, triggered); end
        for (int i = 0; i < n_armed; i++) begin
            sample(gap, 1'b0);
            if (i == 0) begin
                checks++; if (set_armed !== 1'b1) begin errors++; $display("FAIL %s armed_rise: set_armed=%b, required 1", tag, set_armed); end
            end
        end
        for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, 1'b0);
        checks++; if (waddr !== exp_addr) begin errors++; $display("FAIL %s pre_trig_waddr: waddr=%0d, required %0d", tag, waddr, exp_addr); end
        ta = exp_addr;
        cycle(p != 0, 1'b1, p != 0);
        checks++; if (triggered !== 1'b1 || trig_addr !== ta) begin errors++; $display("FAIL %s trigger: triggered=%b trig_addr=%0d, required 1 %0d", tag, triggered, trig_addr, ta); end
        for (int i = 1; i < p; i++) begin
            checks++; if (capture_done !== 1'b0) begin errors++; $display("FAIL %s early_done: capture_done=%b after %0d post writes, required 0", tag, capture_done, i); end
            sample(gap, 1'b0);
        end
        finish_capture(tag);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; trig_pos = '0; trig_in = 1'b0; smpl_en = 1'b0; done_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({set_armed, we, triggered, capture_done, busy} !== 5'b0 || waddr !== '0 || trig_addr !== '0) begin errors++; $display("FAIL reset: armed/we/trig/done/busy=%b waddr=%0d trig_addr=%0d, required 0s", {set_armed, we, triggered, capture_done, busy}, waddr, trig_addr); end
        rst = 1'b0;
        done_ack = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        done_ack = 1'b0;
        checks++; if (busy !== 1'b0 || waddr !== '0) begin errors++; $display("FAIL idle_ignore: busy=%b waddr=%0d, required 0 0", busy, waddr); end
    endtask

    task automatic test_basic;
        capture("basic", 4, 9, 0, 1'b0);
    endtask

    task automatic test_fill_trig;
        capture("fill_trig", 2, 0, 0, 1'b1);
    endtask

    task automatic test_post_bounds;
        capture("pos_zero", 0, 1, 0, 1'b0);
        capture("pos_clamp", 20, 0, 0, 1'b0);
    endtask

    task automatic test_sparse;
        capture("sparse", 4, 8, 2, 1'b0);
    endtask

    task automatic test_reset_mid;
        pulse_start(4);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++; if ({set_armed, we, triggered, capture_done, busy} !== 5'b0 || waddr !== '0 || trig_addr !== '0) begin errors++; $display("FAIL reset_mid: armed/we/trig/done/busy=%b waddr=%0d trig_addr=%0d, required 0s", {set_armed, we, triggered, capture_done, busy}, waddr, trig_addr); end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        capture("after_reset", 3, 2, 0, 1'b0);
    endtask

`ifdef CAPTURE_AUTO_TRIG_EN
    task automatic test_auto_trig;
        pulse_start(2);
        for (int i = 0; i < ENTRIES - 2; i++) sample(0, 1'b0);
        for (int i = 0; i < AUTO_TIMEOUT - 1; i++) cycle(1'b0, 1'b0, 1'b0);
        checks++; if (set_armed !== 1'b1 || auto_trig !== 1'b0) begin errors++; $display("FAIL auto_wait: set_armed=%b auto_trig=%b, required 1 0", set_armed, auto_trig); end
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (auto_trig !== 1'b1 || triggered !== 1'b0 || set_armed !== 1'b0 || trig_addr !== ADDR_W'(ENTRIES - 2)) begin errors++; $display("FAIL auto_fire: auto_trig=%b triggered=%b set_armed=%b trig_addr=%0d, required 1 0 0 %0d", auto_trig, triggered, set_armed, trig_addr, ENTRIES - 2); end
        sample(0, 1'b0);
        checks++; if (capture_done !== 1'b0) begin errors++; $display("FAIL auto_early_done: capture_done=%b, required 0", capture_done); end
        sample(0, 1'b0);
        finish_capture("auto");
        pulse_start(2);
        checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL auto_clear: auto_trig=%b, required 0", auto_trig); end
        rst = 1'b1;
        #1 rst = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill_trig();
        test_post_bounds();
        test_sparse();
        test_reset_mid();
`ifdef CAPTURE_AUTO_TRIG_EN
        test_auto_trig();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
